// File: rtl/simple_ram_burst_master_if.sv
// rtl/simple_ram_burst_master_if.sv - command, write/read stream and SimpleRAM signals for the burst master
interface simple_ram_burst_master_if #(
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd_data;
  logic             done;
  logic             ram_cen;
  logic             ram_wen;
  logic [31:0]      ram_addr;
  logic [31:0]      ram_din;
  logic [31:0]      ram_dout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output done,
    output ram_cen, ram_wen, ram_addr, ram_din,
    input  ram_dout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  done,
    input  ram_cen, ram_wen, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/simple_ram_burst_master.sv
// rtl/simple_ram_burst_master.sv - burst read/write initiator for SimpleRAM with credit-limited read FIFO
module simple_ram_burst_master #(
  parameter int LEN_W    = 16,
  parameter int RD_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  simple_ram_burst_master_if.master bus
);
  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RD_WAIT} state_t;

  state_t          state, state_nxt;
  logic [31:0]     cur_addr;
  logic [LEN_W:0]  remaining;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   inflight;
  logic [PW-1:0]   wptr, rptr;
  logic [31:0]     fifo_mem [RD_DEPTH];
  logic            rd_pend;
  logic            done_wr;
  logic            accept, wr_fire, issue, rd_done;
  logic            push, pop, last_beat;
  logic [CW:0]     credit;

  // A read issued in cycle t returns on ram_dout during t+2; rd_pend marks that cycle.
  assign push      = rd_pend;
  assign pop       = bus.rd_valid & bus.rd_ready;
  assign last_beat = (remaining == (LEN_W+1)'(1));
  assign credit    = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(pop);

  assign bus.rd_valid = (fifo_count != '0);
  assign bus.rd_data  = fifo_mem[rptr];
  assign bus.done     = done_wr | rd_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    wr_fire       = 1'b0;
    issue         = 1'b0;
    rd_done       = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = ~rst;
        accept        = bus.cmd_valid & ~rst;
        if (accept) state_nxt = bus.cmd_write ? WRITE : READ;
      end
      WRITE: begin
        bus.wr_ready = 1'b1;
        wr_fire      = bus.wr_valid;
        if (wr_fire && last_beat) state_nxt = IDLE;
      end
      READ: begin
        issue = (credit < (CW+1)'(RD_DEPTH));
        if (issue && last_beat) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        rd_done = (inflight == '0) && (fifo_count == CW'(1)) && pop;
        if (rd_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr     <= '0;
      remaining    <= '0;
      bus.ram_cen  <= 1'b0;
      bus.ram_wen  <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      done_wr      <= 1'b0;
      rd_pend      <= 1'b0;
      inflight     <= '0;
      fifo_count   <= '0;
      wptr         <= '0;
      rptr         <= '0;
    end else begin
      if (accept) begin
        cur_addr  <= bus.cmd_addr;
        remaining <= (LEN_W+1)'(bus.cmd_len) + (LEN_W+1)'(1);
      end else if (wr_fire || issue) begin
        cur_addr  <= cur_addr + 32'd4;
        remaining <= remaining - (LEN_W+1)'(1);
      end
      bus.ram_cen  <= wr_fire | issue;
      bus.ram_wen  <= wr_fire;
      bus.ram_addr <= (wr_fire | issue) ? cur_addr : '0;
      bus.ram_din  <= wr_fire ? bus.wr_data : '0;
      done_wr      <= wr_fire & last_beat;
      rd_pend      <= bus.ram_cen & ~bus.ram_wen;
      inflight     <= inflight + CW'(issue) - CW'(push);
      fifo_count   <= fifo_count + CW'(push) - CW'(pop);
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= bus.ram_dout;
  end

  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_count == CW'(RD_DEPTH)));
endmodule

// File: tb/tb_simple_ram_burst_master.sv
// tb/tb_simple_ram_burst_master.sv - directed table-driven bench for simple_ram_burst_master
module tb_simple_ram_burst_master;
  localparam int LEN_W    = 16;
  localparam int RD_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simple_ram_burst_master_if #(.LEN_W(LEN_W)) bus();
  simple_ram_burst_master #(.LEN_W(LEN_W), .RD_DEPTH(RD_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_word(a);
  endfunction

  // SimpleRAM model: one-cycle registered read
  always @(posedge clk) begin
    if (bus.ram_cen) begin
      if (bus.ram_wen) mem[bus.ram_addr] = bus.ram_din;
      else bus.ram_dout <= mem.exists(bus.ram_addr) ? mem[bus.ram_addr] : init_word(bus.ram_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    int          gap;
    logic [31:0] dbase;
    int          exp_done;
  } vec_t;

  vec_t vecs[9];

  task automatic run_burst(input vec_t v);
    int n = v.len + 1;
    int acc = 0;
    int pops = 0;
    int beat = 0;
    int done_at = -1;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = v.wr; bus.cmd_addr = v.addr; bus.cmd_len = LEN_W'(v.len);
    bus.rd_ready = 1'b1;
    #1 chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      bus.wr_valid = v.wr && (beat < n) && (((cyc - 1) % (v.gap + 1)) == 0);
      bus.wr_data  = v.dbase + 32'(beat);
      #1;
      if (bus.ram_cen) begin
        chk("ram_addr", bus.ram_addr, v.addr + 32'(4 * acc));
        chk("ram_wen", 32'(bus.ram_wen), 32'(v.wr));
        chk("ram_din", bus.ram_din, v.wr ? v.dbase + 32'(acc) : 32'd0);
        acc++;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        shadow[v.addr + 32'(4 * beat)] = v.dbase + 32'(beat);
        beat++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        chk("rd_data", bus.rd_data, exp_word(v.addr + 32'(4 * pops)));
        pops++;
      end
      if (bus.done) begin
        done_at = cyc;
        break;
      end
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    chk("done_cycle", 32'(done_at), 32'(v.exp_done));
    chk("access_count", 32'(acc), 32'(n));
    chk("pop_count", 32'(pops), v.wr ? 32'd0 : 32'(n));
    @(negedge clk);
    #1;
    chk("done_single_pulse", 32'(bus.done), 32'd0);
    chk("cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
    chk("ram_cen_after", 32'(bus.ram_cen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int issued;
    int pops;
    int done_at;
    bit busy_ok;
    bit seen;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;

    vecs[0] = '{1'b0, 32'h0000_0100, 3, 0, 32'h0, 7};
    vecs[1] = '{1'b1, 32'h0000_0020, 2, 2, 32'hA, 8};
    vecs[2] = '{1'b0, 32'h0000_0020, 2, 0, 32'h0, 6};
    vecs[3] = '{1'b0, 32'hFFFF_FFF8, 2, 0, 32'h0, 6};
    vecs[4] = '{1'b1, 32'h0000_0040, 0, 0, 32'h1234_5678, 2};
    vecs[5] = '{1'b0, 32'h0000_0040, 0, 0, 32'h0, 4};
    vecs[6] = '{1'b0, 32'h0000_0202, 1, 0, 32'h0, 5};
    vecs[7] = '{1'b1, 32'hFFFF_FFFC, 1, 1, 32'hCAFE_0000, 4};
    vecs[8] = '{1'b0, 32'hFFFF_FFFC, 1, 0, 32'h0, 5};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ram_cen", 32'(bus.ram_cen), 32'd0);
    chk("rst_ram_wen", 32'(bus.ram_wen), 32'd0);
    chk("rst_ram_addr", bus.ram_addr, 32'd0);
    chk("rst_ram_din", bus.ram_din, 32'd0);

    for (int i = 0; i < 9; i++) run_burst(vecs[i]);

    // backpressure: only RD_DEPTH reads may be outstanding
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h300; bus.cmd_len = LEN_W'(9);
    bus.rd_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    issued = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.ram_cen) issued++;
      @(negedge clk);
    end
    #1;
    chk("bp_issued", 32'(issued), 32'(RD_DEPTH));
    chk("bp_ram_cen", 32'(bus.ram_cen), 32'd0);
    chk("bp_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("bp_head", bus.rd_data, exp_word(32'h300));
    @(negedge clk);
    bus.rd_ready = 1'b1;
    pops = 0; seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.rd_valid) begin
        chk("bp_drain", bus.rd_data, exp_word(32'h300 + 32'(4 * pops)));
        pops++;
      end
      if (bus.done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp_pops", 32'(pops), 32'd10);
    chk("bp_done", 32'(seen), 32'd1);

    // busy: held command accepted only the cycle after done
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h400; bus.cmd_len = LEN_W'(1);
    #1 chk("busy_first_accept", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_addr = 32'h500; bus.cmd_len = '0;
    busy_ok = 1'b1; done_at = -1;
    for (int c = 1; c <= 30; c++) begin
      #1;
      if (bus.cmd_ready) busy_ok = 1'b0;
      if (bus.done) begin done_at = c; break; end
      @(negedge clk);
    end
    chk("busy_cmd_ready_low", 32'(busy_ok), 32'd1);
    chk("busy_done_cycle", 32'(done_at), 32'd5);
    @(negedge clk);
    #1 chk("busy_second_accept", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.rd_valid) begin
        chk("busy_second_data", bus.rd_data, exp_word(32'h500));
        seen = 1'b1;
        chk("busy_second_done", 32'(bus.done), 32'd1);
        break;
      end
      @(negedge clk);
    end
    chk("busy_second_seen", 32'(seen), 32'd1);

    // reset mid-read after two issues
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h600; bus.cmd_len = LEN_W'(7);
    bus.rd_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    #1 chk("mid_ram_cen_before", 32'(bus.ram_cen), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ram_cen", 32'(bus.ram_cen), 32'd0);
    chk("mid_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1 if (bus.done || bus.rd_valid || bus.ram_cen) seen = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      #1 if (bus.done || bus.rd_valid || bus.ram_cen) seen = 1'b1;
      @(negedge clk);
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    run_burst(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simple_ram_burst_master.md
Name: simple_ram_burst_master

Overview:
Initiator for the team's single-port SimpleRAM interface (cen/wen/addr/din/dout, byte-addressed, 32-bit big-endian word, 1-cycle registered read).
- Accepts burst read/write commands over a valid/ready command port.
- Streams write beats in and read words out over valid/ready data ports, absorbing RAM read latency with a small credit-controlled FIFO.
- Sits between NNA compute/DMA engines and the shared RAM model.

Parameters:
LEN_W, 16, width of cmd_len; burst beats = cmd_len+1 (1..2^LEN_W)
RD_DEPTH, 4, read-data FIFO depth in words (power of 2, >=4 for full throughput)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  32  byte address of first word
cmd_len  in  LEN_W  beats minus one
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accept
wr_data  in  32  write beat data
rd_valid  out  1  read word valid (FIFO not empty)
rd_ready  in  1  consumer accept
rd_data  out  32  FIFO head word
done  out  1  one-cycle pulse at burst completion
ram_cen  out  1  registered chip enable to RAM
ram_wen  out  1  registered write enable to RAM
ram_addr  out  32  registered byte address
ram_din  out  32  registered write data
ram_dout  in  32  RAM read data, valid 1 cycle after RAM samples a read

Behaviour:
- Reset (async, immediate): state=IDLE. cmd_ready=1 once rst deasserts. wr_ready=0, rd_valid=0, done=0. ram_cen=ram_wen=0, ram_addr=ram_din=0. FIFO and counters cleared. An in-progress burst is abandoned; no partial completion or done.
- RAM-side outputs are registers. When no access is issued in a cycle, next cycle has ram_cen=0, ram_wen=0, ram_addr=0, ram_din=0.
- States: IDLE, WRITE, READ, RD_WAIT.
- IDLE:
  - cmd_valid & cmd_ready captures addr and beats=cmd_len+1.
  - Next state is WRITE if cmd_write else READ.
  - cmd_valid in any other state is not accepted (cmd_ready=0).
- WRITE:
  - wr_ready=1.
  - Each handshake registers ram_cen=1, ram_wen=1, ram_addr=cur_addr, ram_din=wr_data for the next cycle.
  - cur_addr += 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - On the last beat's handshake, state goes to IDLE; done pulses in the cycle the last write is presented on ram_* (handshake+1).
  - wr_valid gaps insert idle RAM cycles.
- READ:
  - Issue condition each cycle: fifo_count + inflight - pop < RD_DEPTH, with pop = rd_valid & rd_ready.
  - An issue registers ram_cen=1, ram_wen=0, ram_addr=cur_addr, then cur_addr += 4 (wraps).
  - inflight increments on issue and decrements on push.
  - Push into FIFO occurs 2 cycles after issue (issue cycle t, RAM samples at end of t+1, ram_dout captured at end of t+2).
  - With rd_ready held high, throughput is 1 word/cycle.
  - After the last issue, go to RD_WAIT.
- RD_WAIT: no issues. When inflight=0 and the final word is popped, done pulses in that pop cycle and state goes to IDLE.
- FIFO:
  - First-word-fallthrough; rd_data=head, rd_valid=count!=0.
  - Simultaneous push and pop leave count unchanged.
  - Credit rule guarantees no overflow; push when full is a design error (assertion).
- Ordering: read words return in issue order. Word at address A = {mem[A],mem[A+1],mem[A+2],mem[A+3]}; the block does not reorder bytes. Unaligned addresses are passed through unchanged.
- Single-beat bursts (cmd_len=0) behave identically with one access.
- The back-to-back next command is accepted the cycle after done (IDLE).

Test Plan:
- Read, addr=0x100, len=3, rd_ready=1: ram_addr 0x100,0x104,0x108,0x10C on 4 consecutive cycles with ram_cen=1, ram_wen=0. rd_data returns 4 words in order on consecutive cycles, first 3 cycles after issue. done pulses with the 4th pop.
- Read, len=9, rd_ready=0 throughout: exactly RD_DEPTH=4 reads issued, then ram_cen=0. rd_valid=1 with word 0. Raising rd_ready drains all 10 in order, with no lost or duplicated words.
- Write, addr=0x20, len=2, data 0xA,0xB,0xC, with wr_valid low for 2 cycles between beats: ram_wen=1 writes to 0x20,0x24,0x28 with matching din, idle cycles during gaps. done when the 3rd write is presented. A readback via a read burst returns 0xA,0xB,0xC.
- Wrap: read addr=0xFFFFFFF8, len=2: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Busy: cmd_valid held during a read burst: cmd_ready=0, the second command is accepted the cycle after done.
- Reset mid-read after 2 issues: ram_cen drops to 0 immediately, rd_valid=0, no done. A new command after reset completes normally.
